// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, FSM encoding, GF(2^8) helpers and the S-box.
// The S-box is computed as the GF(2^8) inverse followed by the affine map.
package aes_pkg;
  localparam int WORD_W = 32;
  localparam int RK_W   = 128;

  // Bit n set means NK = n is a supported key length.
  localparam logic [8:0] NK_LEGAL = 9'b1_0101_0000;

  function automatic int key_w(input int nk);
    return WORD_W * nk;
  endfunction

  function automatic bit nk_legal(input int nk);
    return (nk >= 0) && (nk <= 8) && NK_LEGAL[nk];
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_READY} ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse is x^254; square-and-multiply over the bit pattern 1111_1110.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      r = gf_mul(r, r);
      r = gf_mul(r, x);
    end
    r = gf_mul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_subword.sv
// SubWord: independent S-box substitution of each byte of a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
  end
endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES key expansion: one schedule word per cycle into a word file,
// with a registered 128-bit round-key read port.
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter  int NK = 4,
  localparam int NR = NK + 6,
  localparam int NW = 4 * (NR + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [32*NK-1:0]     key_in,
  output logic                 busy,
  output logic                 done,
  output logic                 keys_valid,
  input  logic                 rk_req,
  input  logic [3:0]           rk_round,
  output logic                 rk_valid,
  output logic [RK_W-1:0]      rk_out
);
  localparam int IW = $clog2(NW);
  localparam int KW = key_w(NK);

  if (!nk_legal(NK)) begin : g_nk_chk
    $error("aes_key_schedule_ctrl: NK must be 4, 6 or 8");
  end

  ks_state_e         state_q, state_d;
  logic [IW-1:0]     i_q;
  logic [2:0]        j_q;
  logic [7:0]        rcon_q;
  logic              done_q, kv_q, rkv_q;
  logic [RK_W-1:0]   rk_q;
  logic [WORD_W-1:0] wfile [NW];

  logic              hs, expand, last_w, rd_ok;
  logic [WORD_W-1:0] w_prev, w_old, sub_in, sub_out, w_new;
  logic [IW-1:0]     rd_base;

  assign hs      = key_valid && key_ready;
  assign expand  = (state_q == ST_EXPAND);
  assign last_w  = expand && (i_q == IW'(NW - 1));
  assign rd_ok   = rk_req && kv_q && (rk_round <= 4'(NR));
  assign rd_base = IW'({rk_round, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_READY: if (hs) state_d = ST_EXPAND;
      ST_EXPAND:         if (last_w) state_d = ST_READY;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    key_ready = (state_q != ST_EXPAND);
    busy      = (state_q == ST_EXPAND);
  end

  assign w_prev = wfile[i_q - IW'(1)];
  assign w_old  = wfile[i_q - IW'(NK)];
  assign sub_in = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    w_new = w_prev ^ w_old;
    if (j_q == 3'd0)                  w_new = sub_out ^ {rcon_q, 24'h0} ^ w_old;
    else if (NK == 8 && j_q == 3'd4)  w_new = sub_out ^ w_old;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q    <= '0;
      j_q    <= '0;
      rcon_q <= 8'h01;
      done_q <= 1'b0;
      kv_q   <= 1'b0;
      rkv_q  <= 1'b0;
      rk_q   <= '0;
    end else begin
      done_q <= last_w;
      if (hs) begin
        i_q    <= IW'(NK);
        j_q    <= '0;
        rcon_q <= 8'h01;
        kv_q   <= 1'b0;
      end else if (expand) begin
        i_q <= i_q + IW'(1);
        j_q <= (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
        if (last_w)      kv_q   <= 1'b1;
      end
      // Reads sample the file before any same-edge key load overwrites it.
      rkv_q <= rd_ok;
      if (rd_ok)
        rk_q <= {wfile[rd_base], wfile[rd_base + IW'(1)],
                 wfile[rd_base + IW'(2)], wfile[rd_base + IW'(3)]};
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      for (int k = 0; k < NK; k++) wfile[k] <= key_in[KW-1-32*k -: 32];
    end else if (expand) begin
      wfile[i_q] <= w_new;
    end
  end

  assign done       = done_q;
  assign keys_valid = kv_q;
  assign rk_valid   = rkv_q;
  assign rk_out     = rk_q;
endmodule
